// File: rtl/result_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// result_tx_serializer_if
//   Bundles the test-controller handshake and the serial result line of the
//   result transmitter.
//
//   Signals:
//     start_tx    : level request from the controller, held until tx_finish.
//     result_data : result word, 8*NUM_BYTES bits, byte 0 = bits [7:0].
//     uart_txd    : serial line, idle high.
//     tx_busy     : high while a frame is being shifted.
//     tx_finish   : one-cycle pulse at frame completion.
//
//   Modports:
//     master : controller side (drives request and data, observes line/status).
//     slave  : serializer side (consumes request and data, drives line/status).
// ---------------------------------------------------------------------------
interface result_tx_serializer_if #(
  parameter int NUM_BYTES = 4
);
  logic                   start_tx;
  logic [8*NUM_BYTES-1:0] result_data;
  logic                   uart_txd;
  logic                   tx_busy;
  logic                   tx_finish;

  modport master (
    output start_tx,
    output result_data,
    input  uart_txd,
    input  tx_busy,
    input  tx_finish
  );

  modport slave (
    input  start_tx,
    input  result_data,
    output uart_txd,
    output tx_busy,
    output tx_finish
  );
endinterface

// File: rtl/result_tx_serializer.sv
// ---------------------------------------------------------------------------
// result_tx_serializer
//   Sends a latched result word over a UART-style line (8N1, LSB first),
//   byte 0 first, bytes back to back with no idle bits between them.
//   A frame is requested by a rising level on start_tx; the request must be
//   seen low in IDLE (arm) before another frame can start.
//
//   Parameters:
//     CLKS_PER_BIT : clock cycles per line bit (2..4095).
//     NUM_BYTES    : result bytes per frame (1..16).
//
//   Ports:
//     clk    : system clock, rising edge.
//     reset  : asynchronous, active-high; aborts any frame, line goes high.
//     tx_if  : slave modport of result_tx_serializer_if
//              (start_tx, result_data in; uart_txd, tx_busy, tx_finish out).
//
//   Build option:
//     TX_CHECKSUM_EN : when defined, one extra byte equal to the XOR of all
//                      latched result bytes is appended to each frame.
// ---------------------------------------------------------------------------
module result_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_BYTES    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  result_tx_serializer_if.slave tx_if
);

`ifdef TX_CHECKSUM_EN
  localparam int NB_TOT = NUM_BYTES + 1;
`else
  localparam int NB_TOT = NUM_BYTES;
`endif
  localparam int BIDX_W = (NB_TOT > 1) ? $clog2(NB_TOT) : 1;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(NB_TOT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    arm_q, arm_d;
  logic [NB_TOT-1:0][7:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [BIDX_W-1:0]       byte_q, byte_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    fin_q, fin_d;

  logic [NB_TOT-1:0][7:0]  frame_in;
  logic [7:0]              cur_byte;
  logic [2:0]              bit_nxt;
  logic [CNT_W-1:0]        cnt_dec;

`ifdef TX_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [NUM_BYTES-1:0][7:0] d);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      acc = acc ^ d[i];
    end
    return acc;
  endfunction

  // Checksum is computed from the same input word that gets latched, so it
  // always matches the bytes actually sent.
  assign frame_in = {xor_bytes(tx_if.result_data), tx_if.result_data};
`else
  assign frame_in = tx_if.result_data;
`endif

  assign cur_byte = shadow_q[byte_q];
  assign bit_nxt  = bit_q + 3'd1;
  assign cnt_dec  = cnt_q - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    arm_d    = arm_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    fin_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (!tx_if.start_tx) begin
          arm_d = 1'b1;
        end else if (arm_q) begin
          // Latch cycle: outputs switch to the start bit on this edge.
          arm_d    = 1'b0;
          shadow_d = frame_in;
          state_d  = START;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = CNT_RELOAD;
          byte_d   = '0;
          bit_d    = '0;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          txd_d   = cur_byte[0];
          bit_d   = '0;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nxt;
            txd_d = cur_byte[bit_nxt];
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end

      // The final cycle of the stop bit is spent in NEXT, so the byte
      // decision costs no line time and the next start bit follows directly.
      STOP: begin
        cnt_d = cnt_dec;
        if (cnt_q == CNT_W'(1)) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (byte_q == LAST_BYTE) begin
          state_d = DONE;
          fin_d   = 1'b1;
          busy_d  = 1'b0;
          txd_d   = 1'b1;
        end else begin
          state_d = START;
          byte_d  = byte_q + BIDX_W'(1);
          txd_d   = 1'b0;
          cnt_d   = CNT_RELOAD;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      arm_q    <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      arm_q    <= arm_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
    end
  end

  assign tx_if.uart_txd  = txd_q;
  assign tx_if.tx_busy   = busy_q;
  assign tx_if.tx_finish = fin_q;

endmodule

// File: tb/tb_result_tx_serializer.sv
module tb_result_tx_serializer;
  localparam int CLKS = 4;
  localparam int NB   = 2;
`ifdef TX_CHECKSUM_EN
  localparam int NB_TX = NB + 1;
`else
  localparam int NB_TX = NB;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  result_tx_serializer_if #(.NUM_BYTES(NB)) tif ();

  result_tx_serializer #(
    .CLKS_PER_BIT(CLKS),
    .NUM_BYTES   (NB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tx_if(tif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receives one frame starting at the current negedge. exp_lat is the number
  // of negedges until the start bit must appear; drop_at (>=0) drops start_tx
  // at that line cycle of the frame.
  task automatic recv_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input int exp_lat, input int drop_at);
    logic [7:0] exp_b [NB_TX];
    logic [9:0] word;
    int wait_cyc, glitch, busy_low, fin_hi, n;
    exp_b[0] = e0;
    exp_b[1] = e1;
`ifdef TX_CHECKSUM_EN
    exp_b[2] = e0 ^ e1;
`endif
    wait_cyc = 0;
    while (tif.uart_txd !== 1'b0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check($sformatf("%s_start", name), 32'(tif.uart_txd), 32'd0);
    if (tif.uart_txd !== 1'b0) return;
    check($sformatf("%s_latency", name), 32'(wait_cyc), 32'(exp_lat));
    glitch = 0; busy_low = 0; fin_hi = 0; n = 0;
    word = '0;
    for (int k = 0; k < NB_TX; k++) begin
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < CLKS; c++) begin
          if (c == 0) word[j] = tif.uart_txd;
          else if (tif.uart_txd !== word[j]) glitch++;
          if (tif.tx_busy !== 1'b1) busy_low++;
          if (tif.tx_finish !== 1'b0) fin_hi++;
          if (n == drop_at) tif.start_tx = 1'b0;
          n++;
          @(negedge clk);
        end
      end
      check($sformatf("%s_byte%0d", name, k), 32'(word), 32'({1'b1, exp_b[k], 1'b0}));
    end
    check($sformatf("%s_bit_len", name), 32'(glitch), 32'd0);
    check($sformatf("%s_busy_in_frame", name), 32'(busy_low), 32'd0);
    check($sformatf("%s_early_finish", name), 32'(fin_hi), 32'd0);
    // Now exactly 10*CLKS*NB_TX cycles after the first start-bit cycle.
    check($sformatf("%s_finish", name), 32'(tif.tx_finish), 32'd1);
    check($sformatf("%s_busy_done", name), 32'(tif.tx_busy), 32'd0);
    check($sformatf("%s_idle_line", name), 32'(tif.uart_txd), 32'd1);
    @(negedge clk);
    check($sformatf("%s_finish_end", name), 32'(tif.tx_finish), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, bz, fh, w;
    tif.start_tx    = 1'b0;
    tif.result_data = '0;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(tif.uart_txd), 32'd1);
    check("rst_busy", 32'(tif.tx_busy), 32'd0);
    check("rst_finish", 32'(tif.tx_finish), 32'd0);
    reset = 1'b0;

    // Frame 1: A55A, input changed after the latch edge.
    repeat (10) @(negedge clk);
    tif.result_data = 16'hA55A;
    tif.start_tx    = 1'b1;
    @(negedge clk);
    tif.result_data = 16'hFFFF;
    recv_frame("f1", 8'h5A, 8'hA5, 0, -1);

    // start_tx still held: no new frame.
    lo = 0; bz = 0; fh = 0;
    repeat (200) begin
      @(negedge clk);
      if (tif.uart_txd !== 1'b1) lo++;
      if (tif.tx_busy !== 1'b0) bz++;
      if (tif.tx_finish !== 1'b0) fh++;
    end
    check("hold_txd_low", 32'(lo), 32'd0);
    check("hold_busy", 32'(bz), 32'd0);
    check("hold_finish", 32'(fh), 32'd0);

    // Frame 2: re-arm by a one-cycle drop.
    tif.result_data = 16'h1E87;
    tif.start_tx    = 1'b0;
    @(negedge clk);
    tif.start_tx = 1'b1;
    recv_frame("f2", 8'h87, 8'h1E, 1, -1);

    // Frame 3: start_tx dropped mid-frame.
    tif.result_data = 16'h8001;
    tif.start_tx    = 1'b0;
    @(negedge clk);
    tif.start_tx = 1'b1;
    recv_frame("f3", 8'h01, 8'h80, 1, 30);

    // Frame 4: reset at cycle 30 (byte 0 data bit 6 of 8'h3C is low).
    tif.result_data = 16'h5A3C;
    @(negedge clk);
    tif.start_tx = 1'b1;
    w = 0;
    while (tif.uart_txd !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("f4_start", 32'(tif.uart_txd), 32'd0);
    repeat (30) @(negedge clk);
    check("f4_pre_reset_txd", 32'(tif.uart_txd), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("f4_reset_txd", 32'(tif.uart_txd), 32'd1);
    check("f4_reset_busy", 32'(tif.tx_busy), 32'd0);
    @(negedge clk);
    lo = 0; fh = 0;
    repeat (3) begin
      @(negedge clk);
      if (tif.uart_txd !== 1'b1) lo++;
      if (tif.tx_finish !== 1'b0) fh++;
    end
    reset = 1'b0;
    // start_tx still high after reset: arm was cleared, so nothing starts.
    repeat (20) begin
      @(negedge clk);
      if (tif.uart_txd !== 1'b1) lo++;
      if (tif.tx_finish !== 1'b0) fh++;
    end
    check("f4_after_reset_txd", 32'(lo), 32'd0);
    check("f4_no_finish", 32'(fh), 32'd0);

    // Frame 5: next rise sends a full frame.
    tif.start_tx = 1'b0;
    @(negedge clk);
    tif.start_tx = 1'b1;
    recv_frame("f5", 8'h3C, 8'h5A, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/result_tx_serializer.md
RESULT_TX_SERIALIZER -- requirements
Module: result_tx_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..4095.
REQ-002 Parameter NUM_BYTES, default 4, number of result bytes sent per frame; legal range 1..16.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_tx  input  1  level request from the test controller; held high until tx_finish is returned.
REQ-006 result_data  input  8*NUM_BYTES  result word (transition count, error flags); byte 0 = bits [7:0].
REQ-007 uart_txd  output  1  serial line, idle high.
REQ-008 tx_busy  output  1  high while a frame is being shifted.
REQ-009 tx_finish  output  1  one-cycle pulse at frame completion; drives the controller's txFinish.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, NEXT, DONE, with the transitions in REQ-011 to REQ-016.
REQ-011 Arm flag: set while in IDLE with start_tx low; a transfer SHALL start only if in IDLE, start_tx high and arm set; arm clears on start.
REQ-012 On start, result_data SHALL be latched whole into a shadow register; later input changes do not affect the frame.
REQ-013 The latch cycle SHALL enter START; uart_txd goes low on the next cycle and tx_busy is high from that same cycle.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded to CLKS_PER_BIT-1 at every bit boundary.
REQ-015 Byte format SHALL be START (0), DATA (8 bits, LSB first), STOP (1); byte order 0 .. NUM_BYTES-1.
REQ-016 After STOP, NEXT SHALL increment the byte index and return to START if bytes remain (no extra idle bits); otherwise it goes to DONE.
REQ-017 NEXT SHALL take zero line time: the next start bit follows the previous stop bit directly.
REQ-018 DONE SHALL assert tx_finish for exactly one cycle, drop tx_busy and return to IDLE.
REQ-019 Total frame time from the first start-bit cycle to the tx_finish pulse SHALL be 10*CLKS_PER_BIT*NB cycles. NB = NUM_BYTES, or NUM_BYTES+1 with TX_CHECKSUM_EN.
REQ-020 start_tx still high after tx_finish SHALL NOT start a new frame; start_tx must go low for at least one cycle first (arm rule).
REQ-021 start_tx dropping mid-frame SHALL be ignored; the frame completes and tx_finish still pulses.
REQ-022 Byte index and bit counter widths SHALL be ceil(log2) of their ranges; counters never wrap within a frame.

Reset
REQ-023 Reset SHALL put the FSM in IDLE asynchronously and clear arm, counters and the shadow register.
REQ-024 Output reset values SHALL be uart_txd=1, tx_busy=0, tx_finish=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with no tx_finish pulse; the line returns high asynchronously.

Configuration
REQ-026 Macro TX_CHECKSUM_EN defined: one extra byte SHALL be sent after byte NUM_BYTES-1, equal to the XOR of all latched bytes, in the same format.
REQ-027 Macro TX_CHECKSUM_EN undefined: exactly NUM_BYTES bytes SHALL be sent and no checksum logic SHALL exist.

Verification
REQ-028 Use CLKS_PER_BIT=4, NUM_BYTES=2, result_data=16'hA55A, start_tx high at cycle 10 -> the line reads start,0,1,0,1,1,0,1,0,stop then start,1,0,1,0,0,1,0,1,stop; each bit lasts 4 cycles; tx_finish pulses once 80 cycles after the first start bit.
REQ-029 Hold start_tx high for 200 cycles after tx_finish -> no second frame and uart_txd stays 1; drop start_tx for 1 cycle, then raise it -> a new frame starts.
REQ-030 Change result_data to 16'hFFFF one cycle after start -> the serialized bytes are still 5A then A5.
REQ-031 Assert reset at cycle 30 of a frame -> uart_txd=1 and tx_busy=0 immediately; no tx_finish; the next start_tx rise sends a full frame.
REQ-032 With TX_CHECKSUM_EN, result_data=16'hA55A -> a third byte 8'hFF is sent; tx_finish comes 120 cycles after the first start bit.
REQ-033 Drop start_tx mid-frame -> the frame completes unchanged and tx_finish pulses once.
